// File: rtl/data_memory_loader_pkg.sv
// Shared definitions for the data memory loader.
//   - FSM state encoding (IDLE=0, LOAD=1, RUN=2, DUMP=3, DONE=4)
//   - default RAM geometry (DEPTH bytes, AW index bits)
package data_memory_loader_pkg;

  localparam int DEF_DEPTH = 256;
  localparam int DEF_AW    = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_DUMP = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/data_memory_loader_ram.sv
// data_ram_dp: byte-wide data RAM behind the loader.
//   clk, reset      - system clock; reset clears only the dump read register
//   we/waddr/wdata  - single write port (host or CPU, muxed by the owner)
//   raddr/rdata     - asynchronous read port for the processor
//   re/dump_addr    - registered read port used to stream results out
//   dump_data       - dump read register, loads when re is high
// RAM contents are never cleared.
module data_ram_dp #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata,
  input  logic          re,
  input  logic [AW-1:0] dump_addr,
  output logic [7:0]    dump_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

  always_ff @(posedge clk) begin
    if (reset)   dump_data <= 8'h00;
    else if (re) dump_data <= mem[dump_addr];
  end

endmodule

// File: rtl/data_memory_loader.sv
// data_memory_loader: owns the processor's data RAM.
// Sequence: start -> LOAD (host bytes preload RAM from address 0) -> RUN
// (processor owns the RAM) -> DUMP (result region streamed to host) -> DONE.
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   start, load_count,
//   result_base, result_count   - sequence kick-off and its configuration
//   in_data/in_valid/in_ready   - host preload stream
//   out_data/out_valid/out_ready- result stream to host
//   cpu_addr/cpu_wdata/cpu_we   - processor memory port
//   cpu_finished                - processor done indication
//   cpu_rdata                   - asynchronous read data to processor
//   cpu_run, busy, done         - status
// Optional build macro DUMP_CHECKSUM_EN: DUMP appends one XOR checksum byte
// after the result bytes (also when result_count is 0).
module data_memory_loader
  import data_memory_loader_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW:0]   load_count,
  input  logic [AW-1:0] result_base,
  input  logic [AW:0]   result_count,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  input  logic [15:0]   cpu_addr,
  input  logic [7:0]    cpu_wdata,
  input  logic          cpu_we,
  input  logic          cpu_finished,
  output logic [7:0]    cpu_rdata,
  output logic          cpu_run,
  output logic          busy,
  output logic          done
);

  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  state_t        state, state_nx;
  logic [AW:0]   load_cnt_q, res_cnt_q;
  logic [AW:0]   wcnt, sent;
  logic [AW-1:0] rptr;

  logic          start_ok, host_wr, cpu_in_range, cpu_wr;
  logic          accept, fetch_data, fetch_any, last_accept;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [7:0]    ram_wdata, ram_rdata, ram_dump;

  assign start_ok     = start && (state == ST_IDLE || state == ST_DONE);
  assign host_wr      = in_valid && (state == ST_LOAD);
  assign cpu_in_range = 32'(cpu_addr) < 32'(DEPTH);
  assign cpu_wr       = cpu_we && cpu_in_range && (state == ST_RUN);
  assign accept       = out_valid && out_ready;
  // Data bytes are fetched only when the output slot is empty, which gives
  // the one-cycle gap after DUMP entry and after every accepted byte.
  assign fetch_data   = (state == ST_DUMP) && !out_valid && (sent != res_cnt_q);

`ifdef DUMP_CHECKSUM_EN
  logic [7:0] csum;
  logic       csum_sel;   // output slot currently carries the checksum
  logic       fetch_csum;

  assign fetch_csum  = (state == ST_DUMP) && !out_valid && (sent == res_cnt_q) && !csum_sel;
  assign fetch_any   = fetch_data || fetch_csum;
  assign last_accept = csum_sel;
  assign out_data    = csum_sel ? csum : ram_dump;

  always_ff @(posedge clk) begin
    if (reset) begin
      csum     <= 8'h00;
      csum_sel <= 1'b0;
    end else if (start_ok) begin
      csum     <= 8'h00;
      csum_sel <= 1'b0;
    end else begin
      if (fetch_csum)             csum_sel <= 1'b1;
      if (accept && !csum_sel)    csum     <= csum ^ out_data;
    end
  end
`else
  assign fetch_any   = fetch_data;
  assign last_accept = (sent + CNT_ONE) == res_cnt_q;
  assign out_data    = ram_dump;
`endif

  // Write port: host owns it in LOAD, the processor in RUN.
  assign ram_we    = host_wr || cpu_wr;
  assign ram_waddr = host_wr ? wcnt[AW-1:0] : cpu_addr[AW-1:0];
  assign ram_wdata = host_wr ? in_data : cpu_wdata;

  data_ram_dp #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk       (clk),
    .reset     (reset),
    .we        (ram_we),
    .waddr     (ram_waddr),
    .wdata     (ram_wdata),
    .raddr     (cpu_addr[AW-1:0]),
    .rdata     (ram_rdata),
    .re        (fetch_data),
    .dump_addr (rptr),
    .dump_data (ram_dump)
  );

  assign cpu_rdata = cpu_in_range ? ram_rdata : 8'h00;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    cpu_run  = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        done = (state == ST_DONE);
        if (start) state_nx = (load_count == '0) ? ST_RUN : ST_LOAD;
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && (wcnt + CNT_ONE) == load_cnt_q) state_nx = ST_RUN;
      end
      ST_RUN: begin
        cpu_run = 1'b1;
        busy    = 1'b1;
        if (cpu_finished) begin
`ifdef DUMP_CHECKSUM_EN
          state_nx = ST_DUMP;
`else
          state_nx = (res_cnt_q == '0) ? ST_DONE : ST_DUMP;
`endif
        end
      end
      ST_DUMP: begin
        busy = 1'b1;
        if (accept && last_accept) state_nx = ST_DONE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Counters, latched configuration and the output-valid flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      load_cnt_q <= '0;
      res_cnt_q  <= '0;
      wcnt       <= '0;
      sent       <= '0;
      rptr       <= '0;
      out_valid  <= 1'b0;
    end else if (start_ok) begin
      load_cnt_q <= load_count;
      res_cnt_q  <= result_count;
      wcnt       <= '0;
      sent       <= '0;
      rptr       <= result_base;
      out_valid  <= 1'b0;
    end else begin
      if (host_wr)    wcnt      <= wcnt + CNT_ONE;
      if (fetch_data) rptr      <= rptr + AW'(1);
      if (fetch_any)  out_valid <= 1'b1;
      if (accept) begin
        out_valid <= 1'b0;
        if (sent != res_cnt_q) sent <= sent + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_loader.sv
// Directed bench for data_memory_loader with a scoreboard for dumped bytes.
module tb_data_memory_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [8:0]  load_count;
  logic [7:0]  result_base;
  logic [8:0]  result_count;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic        cpu_finished;
  logic [7:0]  cpu_rdata;
  logic        cpu_run;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;
  logic [7:0] sb[$];
  logic [7:0] xsum;

`ifdef DUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  data_memory_loader dut (
    .clk(clk), .reset(reset), .start(start), .load_count(load_count),
    .result_base(result_base), .result_count(result_count),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
    .cpu_finished(cpu_finished), .cpu_rdata(cpu_rdata), .cpu_run(cpu_run),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input int lc, input int rb, input int rc);
    load_count = 9'(lc); result_base = 8'(rb); result_count = 9'(rc);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic cpu_write(input int a, input int d);
    cpu_addr = 16'(a); cpu_wdata = 8'(d); cpu_we = 1'b1;
    tick();
    cpu_we = 1'b0;
  endtask

  task automatic peek(input string tag, input int a, input int exp);
    cpu_addr = 16'(a);
    #1;
    chk(tag, 32'(cpu_rdata), 32'(exp));
  endtask

  // Feed bytes with in_valid held; returns the number of handshakes seen.
  task automatic feed(input logic [7:0] b[$], input int cycles, output int acc);
    logic hs;
    acc = 0;
    in_valid = 1'b1;
    in_data  = b[0];
    for (int i = 0; i < cycles; i++) begin
      hs = in_ready && in_valid;
      tick();
      if (hs) begin
        acc++;
        in_data = (acc < b.size()) ? b[acc] : 8'h99;
      end
    end
    in_valid = 1'b0;
  endtask

  // Pop-and-compare n output bytes; the first one is stalled for 'stall' cycles.
  task automatic drain(input string tag, input int n, input int stall);
    logic [7:0] d0, exp;
    int w;
    for (int k = 0; k < n; k++) begin
      w = 0;
      while (!out_valid && w < 20) begin tick(); w++; end
      if (!out_valid) begin
        chk({tag, "_timeout"}, 32'(out_valid), 32'd1);
        return;
      end
      if (k == 0 && stall > 0) begin
        d0 = out_data;
        for (int s = 0; s < stall; s++) begin
          tick();
          chk({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
          chk({tag, "_stall_data"}, 32'(out_data), 32'(d0));
        end
      end
      exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
      chk({tag, "_data"}, 32'(out_data), 32'(exp));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  task automatic push_res(input logic [7:0] v[$]);
    xsum = 8'h00;
    foreach (v[i]) begin sb.push_back(v[i]); xsum ^= v[i]; end
    if (CS == 1) sb.push_back(xsum);
  endtask

  initial begin
    int acc;
    logic [7:0] bytes[$];
    reset = 1'b1; start = 1'b0; load_count = '0; result_base = '0; result_count = '0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0; cpu_finished = 1'b0;
    tick(); tick();
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_cpu_run", 32'(cpu_run), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_out_data", 32'(out_data), 0);
    reset = 1'b0;
    tick();

    // Preload four bytes with in_valid held continuously.
    do_start(4, 8'h10, 1);
    chk("load_in_ready", 32'(in_ready), 1);
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    feed(bytes, 8, acc);
    chk("load_accepts", 32'(acc), 4);
    chk("load_cpu_run", 32'(cpu_run), 1);
    chk("run_in_ready", 32'(in_ready), 0);
    peek("rd_addr2", 2, 8'h33);
    peek("rd_addr0", 0, 8'h11);

    // CPU write, out-of-range write, ignored start.
    cpu_write(8'h10, 8'h5A);
    peek("rd_addr10", 8'h10, 8'h5A);
    cpu_write(16'h0100, 8'hFF);
    peek("rd_oor", 16'h0100, 0);
    peek("oor_no_alias", 0, 8'h11);
    do_start(5, 0, 0);
    chk("ign_start_run", 32'(cpu_run), 1);
    chk("ign_start_in_ready", 32'(in_ready), 0);

    // Finish and dump one byte; check the one-cycle fill latency.
    push_res('{8'h5A});
    cpu_finished = 1'b1;
    tick();
    cpu_finished = 1'b0;
    chk("dump_cpu_run_low", 32'(cpu_run), 0);
    chk("dump_entry_valid", 32'(out_valid), 0);
    tick();
    chk("dump_lat_valid", 32'(out_valid), 1);
    drain("d1", 1 + CS, 0);
    chk("d1_done", 32'(done), 1);
    cpu_finished = 1'b1; tick(); cpu_finished = 1'b0;
    chk("fin_in_done_ignored", 32'(done), 1);

    // Backpressure across a wrapping result region FE, FF, 00.
    do_start(0, 8'hFE, 3);
    chk("bp_run", 32'(cpu_run), 1);
    cpu_write(8'hFE, 8'hA1);
    cpu_write(8'hFF, 8'hB2);
    push_res('{8'hA1, 8'hB2, 8'h11});
    cpu_finished = 1'b1; tick(); cpu_finished = 1'b0;
    drain("bp", 3 + CS, 5);
    chk("bp_done", 32'(done), 1);

    // Zero load and result counts.
    do_start(0, 0, 0);
    chk("zero_run", 32'(cpu_run), 1);
    push_res('{});
    cpu_finished = 1'b1; tick(); cpu_finished = 1'b0;
    if (CS == 1) drain("zero", 1, 0);
    chk("zero_done", 32'(done), 1);

    // Reset in the middle of a load keeps what was written.
    do_start(4, 0, 4);
    bytes = '{8'h77, 8'h88};
    feed(bytes, 2, acc);
    chk("mid_accepts", 32'(acc), 2);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mid_in_ready", 32'(in_ready), 0);
    chk("mid_busy", 32'(busy), 0);
    peek("mid_ram0", 0, 8'h77);
    peek("mid_ram1", 1, 8'h88);
    peek("mid_ram2", 2, 8'h33);

    // Full load then dump of the preloaded bytes.
    tick();
    do_start(4, 0, 4);
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    feed(bytes, 6, acc);
    chk("ld2_accepts", 32'(acc), 4);
    push_res(bytes);
    cpu_finished = 1'b1; tick(); cpu_finished = 1'b0;
    drain("ld2", 4 + CS, 2);
    chk("ld2_done", 32'(done), 1);
    chk("sb_empty", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_memory_loader.md
Name: data_memory_loader

Overview:
- Owns the byte-wide data RAM that feeds the processing unit's DATA_FROM_RAM and takes its CPU_ADDRESS, CPU_DATA and CPU_WRITE_EN.
- Before a run, a host byte stream preloads the matrix operands into RAM, then the block releases the processor.
- After the processor signals finish, the block streams the result region back to the host.
- Sits directly between the host link and the processing unit's memory port.

Parameters:
DEPTH, 256, number of RAM bytes; power of two.
AW, 8, RAM index width; log2(DEPTH).

Ports:
clk  input  1  single system clock; all state updates on its rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  one-cycle pulse; begins a load/run/dump sequence.
load_count  input  AW+1  bytes to preload, starting at address 0; sampled on start.
result_base  input  AW  first RAM address of the result region; sampled on start.
result_count  input  AW+1  result bytes to dump; sampled on start.
in_data  input  8  host preload byte.
in_valid  input  1  in_data valid.
in_ready  output  1  block accepts in_data this cycle.
out_data  output  8  result byte to host.
out_valid  output  1  out_data valid.
out_ready  input  1  host accepts out_data.
cpu_addr  input  16  processor address (CPU_ADDRESS).
cpu_wdata  input  8  processor write data (CPU_DATA).
cpu_we  input  1  processor write enable.
cpu_finished  input  1  processor PROCESS_FINISHED.
cpu_rdata  output  8  read data to processor (DATA_FROM_RAM).
cpu_run  output  1  processor may execute; low holds it off.
busy  output  1  high in LOAD, RUN, DUMP.
done  output  1  high in DONE.

Behaviour:
- Reset values:
  - state IDLE.
  - in_ready, out_valid, cpu_run, busy and done all 0.
  - out_data 0; counters 0.
  - RAM contents are not cleared.
- Reset mid-operation aborts to IDLE within one clock; partially loaded RAM is kept.
- States: IDLE, LOAD, RUN, DUMP, DONE.
- IDLE, or DONE, with start=1:
  - Latch the configuration; write pointer = 0.
  - Go to LOAD, or to RUN if load_count = 0.
  - start is ignored in LOAD, RUN and DUMP.
- LOAD:
  - in_ready = 1.
  - When in_valid & in_ready: RAM[wptr] <= in_data; wptr++.
  - After the load_count-th byte is written, go to RUN on the next edge.
  - If load_count > DEPTH, the write pointer wraps modulo DEPTH and the sequence still completes.
- RUN:
  - cpu_run = 1; in_ready = 0.
  - CPU reads are asynchronous: cpu_rdata = RAM[cpu_addr[AW-1:0]] when cpu_addr < DEPTH, else 0.
  - cpu_rdata is driven combinationally in every state, so it is valid before the processor's derived clock edge.
  - Writes: cpu_we=1 with cpu_addr < DEPTH writes cpu_wdata on clk; out-of-range writes are dropped.
  - CPU writes are honoured only in RUN.
  - cpu_finished=1: go to DUMP, or to DONE if result_count = 0.
  - cpu_run drops on the same edge the state leaves RUN.
- DUMP:
  - Read pointer starts at result_base.
  - RAM read is registered: out_data/out_valid appear 1 cycle after entering DUMP, and 1 cycle after each accepted byte.
  - out_data is held stable while out_valid & !out_ready.
  - Read pointer wraps modulo DEPTH.
  - After result_count bytes have been accepted, go to DONE.
- DONE: done = 1 until the next start.
- Simultaneous events:
  - Host input in any state other than LOAD: in_ready = 0, data not consumed.
  - cpu_finished outside RUN is ignored.

Optional Feature:
- Macro: DUMP_CHECKSUM_EN.
- When defined:
  - After the last result byte, DUMP emits one extra byte: the XOR of all dumped result bytes, with the same valid/ready rules.
  - With result_count = 0, DUMP still emits a checksum of 0x00.
- When undefined: no extra byte; result_count = 0 skips directly from RUN to DONE.

Decomposition:
- Shared package:
  - State encoding constants (IDLE=0, LOAD=1, RUN=2, DUMP=3, DONE=4).
  - Default DEPTH/AW.
- One natural sub-module, data_ram_dp:
  - Single write port: muxed host/CPU, chosen by state.
  - Asynchronous CPU read port.
  - Registered dump read port.
- FSM, counters and the muxing stay in data_memory_loader.

Test Plan:
- Preload:
  - Stimulus: start with load_count=4, then in_data 0x11,0x22,0x33,0x44 with in_valid held.
  - Response: in_ready high for exactly 4 accepts, then cpu_run=1; cpu_addr=2 gives cpu_rdata=0x33.
- CPU write and finish:
  - Stimulus: in RUN, cpu_we=1, cpu_addr=0x10, cpu_wdata=0x5A; then cpu_finished=1 with result_base=0x10, result_count=1.
  - Response: out_data=0x5A with out_valid, 1 cycle after DUMP entry; done=1 after accept.
- Backpressure:
  - Stimulus: result_count=3, out_ready low for 5 cycles.
  - Response: out_valid and out_data stable throughout; bytes then delivered in address order.
- Out-of-range access:
  - Stimulus: cpu_addr=0x0100 with cpu_we=1, data 0xFF.
  - Response: RAM unchanged; cpu_rdata=0x00 at 0x0100.
- Zero counts and ignored start:
  - Stimulus: load_count=0, result_count=0; also pulse start during RUN.
  - Response: start goes straight to RUN; cpu_finished goes to DONE (macro off); the start during RUN is ignored.
- Reset mid-LOAD and checksum:
  - Stimulus: reset after 2 of 4 bytes.
  - Response: IDLE, in_ready=0, RAM[0..1] retained.
  - With DUMP_CHECKSUM_EN, dumping 0x11,0x22,0x33,0x44 yields trailing byte 0x44.
